// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: instruction fields, ALU commands,
// FSM states and datapath mux selects.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2a;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  localparam logic [1:0] PC_SEQ    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_JR     = 2'd3;

  localparam logic [1:0] DST_RD = 2'd0;
  localparam logic [1:0] DST_RT = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] M2R_ALU  = 2'd0;
  localparam logic [1:0] M2R_MEM  = 2'd1;
  localparam logic [1:0] M2R_LINK = 2'd2;

  // One-hot instruction class; all zero means unsupported
  typedef struct packed {
    logic add;
    logic sub;
    logic slt;
    logic jr;
    logic j;
    logic jal;
    logic addi;
    logic xori;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
  } instr_class_t;

endpackage

// File: rtl/cpu_multicycle_ctrl_if.sv
// Control bundle between the sequencer (master) and the datapath (slave).
interface cpu_multicycle_ctrl_if #(
  parameter int COUNT_W = 32
);
  logic [5:0]         opcode;
  logic [5:0]         funct;
  logic               alu_zero;
  logic               mem_ready;
  logic               ir_wr;
  logic               pc_wr;
  logic [1:0]         pc_src;
  logic               reg_wr;
  logic [1:0]         reg_dst;
  logic [1:0]         mem_to_reg;
  logic               mem_rd;
  logic               mem_wr;
  logic               alu_src;
  logic [2:0]         alu_ctrl;
  logic               illegal;
  logic [2:0]         state;
  logic [COUNT_W-1:0] instr_count;

  modport master (
    input  opcode, funct, alu_zero, mem_ready,
    output ir_wr, pc_wr, pc_src, reg_wr, reg_dst, mem_to_reg,
           mem_rd, mem_wr, alu_src, alu_ctrl, illegal, state, instr_count
  );

  modport slave (
    output opcode, funct, alu_zero, mem_ready,
    input  ir_wr, pc_wr, pc_src, reg_wr, reg_dst, mem_to_reg,
           mem_rd, mem_wr, alu_src, alu_ctrl, illegal, state, instr_count
  );
endinterface

// File: rtl/cpu_ctrl_decode.sv
// Combinational instruction classifier: opcode/funct to one-hot class plus illegal flag.
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_t cls,
  output logic         illegal
);

  always_comb begin
    cls     = '0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  cls.add = 1'b1;
          FN_SUB:  cls.sub = 1'b1;
          FN_SLT:  cls.slt = 1'b1;
          FN_JR:   cls.jr  = 1'b1;
          default: illegal = 1'b1;
        endcase
      end
      OP_J:    cls.j    = 1'b1;
      OP_JAL:  cls.jal  = 1'b1;
      OP_BEQ:  cls.beq  = 1'b1;
      OP_BNE:  cls.bne  = 1'b1;
      OP_ADDI: cls.addi = 1'b1;
      OP_XORI: cls.xori = 1'b1;
      OP_LW:   cls.lw   = 1'b1;
      OP_SW:   cls.sw   = 1'b1;
      default: illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_multicycle_ctrl.sv
// Multi-cycle sequencer: FSM, per-state strobe/select generation and retired-instruction counter.
module cpu_multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  cpu_multicycle_ctrl_if.master bus
);

  logic [2:0]         state_reg, state_next;
  logic               illegal_reg;
  logic [COUNT_W-1:0] count_reg;

  instr_class_t cls;
  logic         dec_illegal;
  logic         is_jump, is_alu_wb, is_mem, retire;

  logic       ir_wr, pc_wr, reg_wr, mem_rd, mem_wr, alu_src;
  logic [1:0] pc_src, reg_dst, mem_to_reg;
  logic [2:0] alu_ctrl;

  cpu_ctrl_decode u_decode (
    .opcode  (bus.opcode),
    .funct   (bus.funct),
    .cls     (cls),
    .illegal (dec_illegal)
  );

  assign is_jump   = cls.j | cls.jal | cls.jr;
  assign is_alu_wb = cls.add | cls.sub | cls.slt | cls.addi | cls.xori;
  assign is_mem    = cls.lw | cls.sw;

  always_comb begin
    state_next = ST_FETCH;
    case (state_reg)
      ST_FETCH:  state_next = ST_DECODE;
      ST_DECODE: begin
        if (is_jump)          state_next = ST_FETCH;
        else if (dec_illegal) state_next = ST_HALT;
        else                  state_next = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_mem)         state_next = ST_MEM;
        else if (is_alu_wb) state_next = ST_WB;
        else                state_next = ST_FETCH;
      end
      ST_MEM: begin
        if (!bus.mem_ready && is_mem) state_next = ST_MEM;
        else if (cls.lw)              state_next = ST_WB;
        else                          state_next = ST_FETCH;
      end
      ST_WB:   state_next = ST_FETCH;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_FETCH;
    endcase
  end

  // Only real instruction completions count; HALT entry and stray encodings do not
  assign retire = (state_next == ST_FETCH) &&
                  ((state_reg == ST_DECODE) || (state_reg == ST_EXEC) ||
                   (state_reg == ST_MEM)    || (state_reg == ST_WB));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_FETCH;
      illegal_reg <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_DECODE && dec_illegal)
        illegal_reg <= 1'b1;
      if (retire)
        count_reg <= count_reg + 1'b1;
    end
  end

  // Strobes are gated by reset so an in-flight memory access drops immediately
  always_comb begin
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    pc_src     = PC_SEQ;
    reg_wr     = 1'b0;
    reg_dst    = DST_RD;
    mem_to_reg = M2R_ALU;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    alu_src    = 1'b0;
    alu_ctrl   = ALU_ADD;
    if (reset) begin
      case (state_reg)
        ST_FETCH: begin
          ir_wr = 1'b1;
          pc_wr = 1'b1;
        end
        ST_DECODE: begin
          if (cls.j || cls.jal) begin
            pc_wr  = 1'b1;
            pc_src = PC_JUMP;
          end
          if (cls.jal) begin
            reg_wr     = 1'b1;
            reg_dst    = DST_RA;
            mem_to_reg = M2R_LINK;
          end
          if (cls.jr) begin
            pc_wr  = 1'b1;
            pc_src = PC_JR;
          end
        end
        ST_EXEC: begin
          if (cls.sub)                alu_ctrl = ALU_SUB;
          if (cls.slt)                alu_ctrl = ALU_SLT;
          if (cls.xori)               alu_ctrl = ALU_XOR;
          if (cls.addi || cls.xori || is_mem) alu_src = 1'b1;
          if (cls.beq || cls.bne) begin
            alu_ctrl = ALU_SUB;
            pc_src   = PC_BRANCH;
            pc_wr    = cls.beq ? bus.alu_zero : !bus.alu_zero;
          end
        end
        ST_MEM: begin
          alu_src = 1'b1;
          mem_rd  = cls.lw;
          mem_wr  = cls.sw;
        end
        ST_WB: begin
          reg_wr = 1'b1;
          if (cls.addi || cls.xori || cls.lw) reg_dst = DST_RT;
          if (cls.lw)                         mem_to_reg = M2R_MEM;
        end
        default: ;
      endcase
    end
  end

  assign bus.ir_wr       = ir_wr;
  assign bus.pc_wr       = pc_wr;
  assign bus.pc_src      = pc_src;
  assign bus.reg_wr      = reg_wr;
  assign bus.reg_dst     = reg_dst;
  assign bus.mem_to_reg  = mem_to_reg;
  assign bus.mem_rd      = mem_rd;
  assign bus.mem_wr      = mem_wr;
  assign bus.alu_src     = alu_src;
  assign bus.alu_ctrl    = alu_ctrl;
  assign bus.illegal     = illegal_reg;
  assign bus.state       = state_reg;
  assign bus.instr_count = count_reg;

endmodule

// File: tb/tb_cpu_multicycle_ctrl.sv
// Directed bench: builds each instruction's expected per-cycle phase list and checks every cycle.
module tb_cpu_multicycle_ctrl;

  localparam int CW = 4;

  typedef struct packed {
    logic [2:0]    st;
    logic          ir_wr;
    logic          pc_wr;
    logic [1:0]    pc_src;
    logic          reg_wr;
    logic [1:0]    reg_dst;
    logic [1:0]    m2r;
    logic          mem_rd;
    logic          mem_wr;
    logic          alu_src;
    logic [2:0]    alu_ctrl;
    logic          ill;
    logic [CW-1:0] cnt;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cpu_multicycle_ctrl_if #(.COUNT_W(CW)) bus ();
  cpu_multicycle_ctrl #(.COUNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_chk = 0;
  int n_err = 0;
  logic [CW-1:0] m_cnt = '0;
  logic m_ill = 1'b0;
  obs_t exp_o = '0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.st = bus.state;       o.ir_wr = bus.ir_wr;     o.pc_wr = bus.pc_wr;
    o.pc_src = bus.pc_src;  o.reg_wr = bus.reg_wr;   o.reg_dst = bus.reg_dst;
    o.m2r = bus.mem_to_reg; o.mem_rd = bus.mem_rd;   o.mem_wr = bus.mem_wr;
    o.alu_src = bus.alu_src; o.alu_ctrl = bus.alu_ctrl;
    o.ill = bus.illegal;    o.cnt = bus.instr_count;
    return o;
  endfunction

  task automatic compare(input obs_t a, input obs_t e, input string t);
    chk({t, ".state"},       32'(a.st),       32'(e.st));
    chk({t, ".ir_wr"},       32'(a.ir_wr),    32'(e.ir_wr));
    chk({t, ".pc_wr"},       32'(a.pc_wr),    32'(e.pc_wr));
    chk({t, ".pc_src"},      32'(a.pc_src),   32'(e.pc_src));
    chk({t, ".reg_wr"},      32'(a.reg_wr),   32'(e.reg_wr));
    chk({t, ".reg_dst"},     32'(a.reg_dst),  32'(e.reg_dst));
    chk({t, ".mem_to_reg"},  32'(a.m2r),      32'(e.m2r));
    chk({t, ".mem_rd"},      32'(a.mem_rd),   32'(e.mem_rd));
    chk({t, ".mem_wr"},      32'(a.mem_wr),   32'(e.mem_wr));
    chk({t, ".alu_src"},     32'(a.alu_src),  32'(e.alu_src));
    chk({t, ".alu_ctrl"},    32'(a.alu_ctrl), 32'(e.alu_ctrl));
    chk({t, ".illegal"},     32'(a.ill),      32'(e.ill));
    chk({t, ".instr_count"}, 32'(a.cnt),      32'(e.cnt));
  endtask

  always @(negedge clk)
    if (chk_en) compare(sample(), exp_o, "cycle");

  function automatic obs_t blank(input logic [2:0] st);
    obs_t o = '0;
    o.st  = st;
    o.ill = m_ill;
    o.cnt = m_cnt;
    return o;
  endfunction

  // Inputs change 1 time unit after the rising edge; the check happens at the falling edge
  task automatic step(input obs_t e, input logic rdy, input logic z);
    exp_o = e;
    bus.mem_ready = rdy;
    bus.alu_zero = z;
    chk_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string nm);
    #2;
    reset = 1'b0;
    m_cnt = '0;
    m_ill = 1'b0;
    #1;
    compare(sample(), obs_t'(0), {nm, ".async"});
    exp_o = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    $display("txn reset %s released", nm);
  endtask

  // Expected phase list derived from the instruction's behaviour, not the FSM encoding
  task automatic run(input string nm, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input int w, input int abort_at, input int lat_exp);
    obs_t seq[$];
    logic rdy[$];
    obs_t o;
    bit rt, jr, j, jal, addi, xori, lw, sw, beq, bne, legal;
    rt   = (op == 6'h00) && (fn == 6'h20 || fn == 6'h22 || fn == 6'h2a);
    jr   = (op == 6'h00) && (fn == 6'h08);
    j    = (op == 6'h02);
    jal  = (op == 6'h03);
    beq  = (op == 6'h04);
    bne  = (op == 6'h05);
    addi = (op == 6'h08);
    xori = (op == 6'h0e);
    lw   = (op == 6'h23);
    sw   = (op == 6'h2b);
    legal = rt | jr | j | jal | addi | xori | lw | sw | beq | bne;
    bus.opcode = op;
    bus.funct  = fn;

    o = blank(3'd0); o.ir_wr = 1'b1; o.pc_wr = 1'b1;
    seq.push_back(o); rdy.push_back(1'b1);
    o = blank(3'd1);
    if (j || jal) begin o.pc_wr = 1'b1; o.pc_src = 2'd2; end
    if (jal) begin o.reg_wr = 1'b1; o.reg_dst = 2'd2; o.m2r = 2'd2; end
    if (jr) begin o.pc_wr = 1'b1; o.pc_src = 2'd3; end
    seq.push_back(o); rdy.push_back(1'b1);
    if (legal && !(j || jal || jr)) begin
      o = blank(3'd2);
      if (rt) o.alu_ctrl = (fn == 6'h22) ? 3'd1 : (fn == 6'h2a) ? 3'd3 : 3'd0;
      else if (addi || lw || sw) o.alu_src = 1'b1;
      else if (xori) begin o.alu_src = 1'b1; o.alu_ctrl = 3'd2; end
      else begin
        o.alu_ctrl = 3'd1; o.pc_src = 2'd1;
        o.pc_wr = beq ? z : !z;
      end
      seq.push_back(o); rdy.push_back(1'b1);
      if (lw || sw)
        for (int i = 0; i <= w; i++) begin
          o = blank(3'd3); o.alu_src = 1'b1; o.mem_rd = lw; o.mem_wr = sw;
          seq.push_back(o); rdy.push_back(i == w);
        end
      if (rt || addi || xori || lw) begin
        o = blank(3'd4); o.reg_wr = 1'b1;
        o.reg_dst = rt ? 2'd0 : 2'd1;
        o.m2r = lw ? 2'd1 : 2'd0;
        seq.push_back(o); rdy.push_back(1'b1);
      end
    end
    if (lat_exp > 0) chk({nm, ".latency"}, 32'(seq.size()), 32'(lat_exp));

    for (int i = 0; i < seq.size(); i++) begin
      if (i == abort_at) begin
        $display("txn %s op=%02h fn=%02h aborted after %0d cycles", nm, op, fn, i);
        return;
      end
      step(seq[i], rdy[i], z);
    end
    if (legal) m_cnt = m_cnt + 1'b1;
    else m_ill = 1'b1;
    $display("txn %s op=%02h fn=%02h cycles=%0d count=%0d illegal=%0d",
             nm, op, fn, seq.size(), m_cnt, m_ill);
  endtask

  task automatic halt_cycles(input string nm, input int n);
    for (int i = 0; i < n; i++) step(blank(3'd5), 1'b1, i[0]);
    $display("txn %s halt held %0d cycles", nm, n);
  endtask

  initial begin
    bus.opcode = '0; bus.funct = '0; bus.alu_zero = 1'b0; bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset("power_on");

    run("add",  6'h00, 6'h20, 1'b0, 0, -1, 4);
    chk("add.count_lit", 32'(bus.instr_count), 32'd1);
    run("sub",  6'h00, 6'h22, 1'b1, 0, -1, 4);
    run("slt",  6'h00, 6'h2a, 1'b0, 0, -1, 4);
    run("addi", 6'h08, 6'h3f, 1'b0, 0, -1, 4);
    run("xori", 6'h0e, 6'h00, 1'b1, 0, -1, 4);
    run("lw_w3", 6'h23, 6'h00, 1'b0, 3, -1, 8);
    run("lw_w0", 6'h23, 6'h11, 1'b0, 0, -1, 5);
    run("sw_w2", 6'h2b, 6'h00, 1'b0, 2, -1, 6);
    run("sw_w0", 6'h2b, 6'h00, 1'b1, 0, -1, 4);
    run("beq_z1", 6'h04, 6'h00, 1'b1, 0, -1, 3);
    run("beq_z0", 6'h04, 6'h00, 1'b0, 0, -1, 3);
    run("bne_z1", 6'h05, 6'h00, 1'b1, 0, -1, 3);
    run("bne_z0", 6'h05, 6'h00, 1'b0, 0, -1, 3);
    run("j",    6'h02, 6'h00, 1'b0, 0, -1, 2);
    run("jal",  6'h03, 6'h00, 1'b0, 0, -1, 2);
    chk("jal.count_lit", 32'(bus.instr_count), 32'd15);
    run("jr",   6'h00, 6'h08, 1'b0, 0, -1, 2);
    chk("wrap.count_lit", 32'(bus.instr_count), 32'd0);
    run("add2", 6'h00, 6'h20, 1'b0, 0, -1, 4);

    run("lw_abort", 6'h23, 6'h00, 1'b0, 10, 5, 0);
    do_reset("mid_lw");
    run("add3", 6'h00, 6'h20, 1'b0, 0, -1, 4);
    chk("post_reset.count_lit", 32'(bus.instr_count), 32'd1);

    run("ill_op", 6'h3f, 6'h00, 1'b0, 0, -1, 2);
    halt_cycles("ill_op", 10);
    chk("halt.illegal_lit", 32'(bus.illegal), 32'd1);
    chk("halt.count_lit", 32'(bus.instr_count), 32'd1);
    do_reset("clear_illegal");
    chk("reset.illegal_lit", 32'(bus.illegal), 32'd0);

    run("ill_fn", 6'h00, 6'h21, 1'b0, 0, -1, 2);
    halt_cycles("ill_fn", 3);
    do_reset("final");
    run("addi2", 6'h08, 6'h00, 1'b0, 0, -1, 4);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
